// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_e;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 6;
    localparam int DEF_NUM_REGS = 64;
    localparam int DEF_NUM_RD   = 3;
    localparam int DEF_NUM_WR   = 2;

    // ceil(log2(value)); clog2(1) = 0
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // low bit index of port 'port' in a flat bus of 'width'-bit fields
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// Clear-sweep controller: owns the IDLE/SWEEP FSM, the sweep pointer and
// the registered ready flag; drives one zeroing strobe per write slot.
module regfile_sweep_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_WR   = DEF_NUM_WR
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    output logic                     ready,
    output logic [NUM_WR-1:0]        clr_en,
    output logic [NUM_WR*ADDR_W-1:0] clr_addr
);

    // wide enough that sptr + NUM_WR never wraps, even for a full 2**ADDR_W file
    localparam int            SW     = ADDR_W + clog2(NUM_WR) + 1;
    localparam logic [SW-1:0] REGS_W = SW'(NUM_REGS);
    localparam logic [SW-1:0] STEP_W = SW'(NUM_WR);

    rf_state_e         state, state_d;
    logic [ADDR_W-1:0] sptr, sptr_d;
    logic              ready_d;
    logic [SW-1:0]     sptr_next;

    assign sptr_next = {{(SW-ADDR_W){1'b0}}, sptr} + STEP_W;

    // next state: clear (re)starts a sweep, the final beat returns to idle
    always_comb begin
        state_d = state;
        sptr_d  = sptr;
        case (state)
            RF_IDLE: begin
                if (clear) begin
                    state_d = RF_SWEEP;
                    sptr_d  = '0;
                end
            end
            RF_SWEEP: begin
                if (clear) begin
                    sptr_d = '0;
                end else if (sptr_next >= REGS_W) begin
                    state_d = RF_IDLE;
                    sptr_d  = '0;
                end else begin
                    sptr_d = sptr_next[ADDR_W-1:0];
                end
            end
            default: begin
                state_d = RF_SWEEP;
                sptr_d  = '0;
            end
        endcase
        ready_d = (state_d == RF_IDLE);
    end

    // state, pointer and ready register; reset forces a fresh sweep
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RF_SWEEP;
            sptr  <= '0;
            ready <= 1'b0;
        end else begin
            state <= state_d;
            sptr  <= sptr_d;
            ready <= ready_d;
        end
    end

    // one zeroing strobe per slot; slots past the last register stay quiet
    always_comb begin
        logic [SW-1:0] slot;
        slot     = '0;
        clr_en   = '0;
        clr_addr = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            slot      = {{(SW-ADDR_W){1'b0}}, sptr} + SW'(k);
            clr_en[k] = (state == RF_SWEEP) && (slot < REGS_W);
            clr_addr[slice_lo(k, ADDR_W) +: ADDR_W] = slot[ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised multi-port register file with hardware clear sweep.
// Combinational reads, registered writes, highest-numbered write port wins
// on same-address collisions. Optional REGFILE_BYPASS_EN adds same-cycle
// write-to-read forwarding using the same port priority.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int NUM_WR   = DEF_NUM_WR
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    output logic                     ready,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data
);

    localparam int             AW1    = ADDR_W + 1;
    localparam logic [AW1-1:0] REGS_W = AW1'(NUM_REGS);

    logic [DATA_W-1:0]        mem [NUM_REGS];
    logic [NUM_WR-1:0]        clr_en;
    logic [NUM_WR*ADDR_W-1:0] clr_addr;
    logic [NUM_WR-1:0]        wr_ok;

    regfile_sweep_ctrl #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR)
    ) u_sweep (
        .clock    (clock),
        .reset    (reset),
        .clear    (clear),
        .ready    (ready),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    // a write is real only when the file is usable and the target exists
    always_comb begin
        wr_ok = '0;
        for (int j = 0; j < NUM_WR; j++) begin
            wr_ok[j] = ready && wr_en[j] &&
                       ({1'b0, wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]} < REGS_W);
        end
    end

    // storage update; ascending port order lets the highest enabled port land last.
    // Sweep strobes and user writes never overlap because writes need ready=1.
    always_ff @(posedge clock) begin
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_ok[j]) begin
                mem[wr_addr[slice_lo(j, ADDR_W) +: ADDR_W]] <=
                    wr_data[slice_lo(j, DATA_W) +: DATA_W];
            end
        end
        for (int k = 0; k < NUM_WR; k++) begin
            if (clr_en[k]) begin
                mem[clr_addr[slice_lo(k, ADDR_W) +: ADDR_W]] <= '0;
            end
        end
    end

    // read ports: stored value (0 when out of range), optional forwarding, forced 0 while sweeping
    always_comb begin
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] val;
        ra      = '0;
        val     = '0;
        rd_data = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra  = rd_addr[slice_lo(i, ADDR_W) +: ADDR_W];
            val = '0;
            if ({1'b0, ra} < REGS_W) begin
                val = mem[ra];
            end
`ifdef REGFILE_BYPASS_EN
            // later ports override earlier ones, matching commit priority
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_ok[j] && (wr_addr[slice_lo(j, ADDR_W) +: ADDR_W] == ra)) begin
                    val = wr_data[slice_lo(j, DATA_W) +: DATA_W];
                end
            end
`endif
            if (ready) begin
                rd_data[slice_lo(i, DATA_W) +: DATA_W] = val;
            end
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: default 64-entry instance plus a
// 48-entry instance for out-of-range address handling.
module tb_regfile_multiport;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int NR = 3;
    localparam int NW = 2;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic clear = 1'b0;
    logic ready;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rd_data;
    logic [NW-1:0]    wr_en   = '0;
    logic [NW*AW-1:0] wr_addr = '0;
    logic [NW*DW-1:0] wr_data = '0;

    logic clear48 = 1'b0;
    logic ready48;
    logic [NR*AW-1:0] rd_addr48 = '0;
    logic [NR*DW-1:0] rd_data48;
    logic [NW-1:0]    wr_en48   = '0;
    logic [NW*AW-1:0] wr_addr48 = '0;
    logic [NW*DW-1:0] wr_data48 = '0;

    always #5 clock = ~clock;

    regfile_multiport dut (
        .clock(clock), .reset(reset), .clear(clear), .ready(ready),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    regfile_multiport #(.DATA_W(16), .NUM_REGS(48), .ADDR_W(6), .NUM_RD(3), .NUM_WR(2)) dut48 (
        .clock(clock), .reset(reset), .clear(clear48), .ready(ready48),
        .rd_addr(rd_addr48), .rd_data(rd_data48),
        .wr_en(wr_en48), .wr_addr(wr_addr48), .wr_data(wr_data48)
    );

    // sig: 0 ready, 1 rd_data[port], 2 ready48, 3 rd_data48[port]
    typedef struct {
        int          sig;
        int          port;
        logic [15:0] exp;
        string       name;
    } chk_t;

    chk_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [15:0] sample(input int sig, input int port);
        case (sig)
            0:       return {15'b0, ready};
            1:       return rd_data[port*DW +: DW];
            2:       return {15'b0, ready48};
            default: return rd_data48[port*DW +: DW];
        endcase
    endfunction

    task automatic expect_val(input int sig, input int port, input logic [15:0] exp, input string name);
        chk_t c;
        c.sig  = sig;
        c.port = port;
        c.exp  = exp;
        c.name = name;
        sbq.push_back(c);
    endtask

    // immediate check, sampled now
    task automatic check_now(input int sig, input int port, input logic [15:0] exp, input string name);
        logic [15:0] act;
        act = sample(sig, port);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: every expectation queued this cycle is checked at the falling edge
    always @(negedge clock) begin
        while (sbq.size() > 0) begin
            chk_t        c;
            logic [15:0] act;
            c = sbq.pop_front();
            act = sample(c.sig, c.port);
            n_vec++;
            if (act !== c.exp) begin
                n_bad++;
                $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // bounded wait for ready; an expired wait is a failure
    task automatic wait_ready(input int max_cyc, input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        n_vec++;
        if (ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: ready not seen within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic set_rd(input int p, input int a);
        rd_addr[p*AW +: AW] = a[AW-1:0];
    endtask

    task automatic set_wr(input int p, input logic en, input int a, input logic [15:0] d);
        wr_en[p]            = en;
        wr_addr[p*AW +: AW] = a[AW-1:0];
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic set_rd48(input int p, input int a);
        rd_addr48[p*AW +: AW] = a[AW-1:0];
    endtask

    task automatic set_wr48(input int p, input logic en, input int a, input logic [15:0] d);
        wr_en48[p]            = en;
        wr_addr48[p*AW +: AW] = a[AW-1:0];
        wr_data48[p*DW +: DW] = d;
    endtask

    initial begin
        // 1: reset, then exactly 32 not-ready windows, then every entry reads 0
        repeat (2) step();
        expect_val(0, 0, 16'h0, "ready_in_reset");
        check_now(0, 0, 16'h0, "ready_in_reset_now");
        step();
        reset = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) step();
            expect_val(0, 0, (k < 32) ? 16'h0 : 16'h1, "ready_after_reset");
        end
        for (int a = 0; a < 64; a += 3) begin
            step();
            for (int p = 0; p < 3; p++) begin
                set_rd(p, (a + p) % 64);
                expect_val(1, p, 16'h0, "sweep_zero");
            end
        end

        // 2: two ports, two addresses
        step();
        set_wr(0, 1'b1, 5, 16'h1234);
        set_wr(1, 1'b1, 9, 16'hBEEF);
        set_rd(0, 5);
        set_rd(1, 9);
        expect_val(1, 0, BYP ? 16'h1234 : 16'h0000, "same_cycle_r5");
        expect_val(1, 1, BYP ? 16'hBEEF : 16'h0000, "same_cycle_r9");
        step();
        set_wr(0, 1'b0, 0, 16'h0);
        set_wr(1, 1'b0, 0, 16'h0);
        expect_val(1, 0, 16'h1234, "wr_r5");
        expect_val(1, 1, 16'hBEEF, "wr_r9");

        // 3: collision on r7, port1 wins
        step();
        set_wr(0, 1'b1, 7, 16'h1111);
        set_wr(1, 1'b1, 7, 16'h2222);
        set_rd(2, 7);
        expect_val(1, 2, BYP ? 16'h2222 : 16'h0000, "same_cycle_collide");
        step();
        set_wr(0, 1'b0, 0, 16'h0);
        set_wr(1, 1'b0, 0, 16'h0);
        set_rd(0, 7);
        expect_val(1, 0, 16'h2222, "collide_r7_p0");
        expect_val(1, 2, 16'h2222, "collide_r7_p2");

        // 4: write r3 while reading it on port 2
        step();
        set_wr(0, 1'b1, 3, 16'hA5A5);
        set_rd(2, 3);
        expect_val(1, 2, BYP ? 16'hA5A5 : 16'h0000, "bypass_r3");
        step();
        set_wr(0, 1'b0, 0, 16'h0);
        expect_val(1, 2, 16'hA5A5, "r3_next");

        // 5: clear with r10 stored; writes during the sweep are ignored
        step();
        set_wr(0, 1'b1, 10, 16'h0F0F);
        step();
        set_wr(0, 1'b0, 0, 16'h0);
        set_rd(0, 10);
        expect_val(1, 0, 16'h0F0F, "r10_stored");
        clear = 1'b1;
        set_wr(1, 1'b1, 11, 16'h5555);
        set_rd(1, 11);
        expect_val(1, 1, BYP ? 16'h5555 : 16'h0000, "clear_cycle_r11");
        for (int k = 1; k <= 33; k++) begin
            step();
            clear = 1'b0;
            if (k == 1) begin
                set_wr(0, 1'b1, 10, 16'hDEAD);
                set_wr(1, 1'b1, 12, 16'hBEEF);
                set_rd(1, 12);
            end
            if (k == 33) begin
                set_wr(0, 1'b0, 0, 16'h0);
                set_wr(1, 1'b0, 0, 16'h0);
            end
            expect_val(0, 0, (k < 33) ? 16'h0 : 16'h1, "ready_clear");
            expect_val(1, 0, 16'h0, "r10_during_sweep");
        end
        step();
        set_rd(0, 10);
        set_rd(1, 11);
        set_rd(2, 12);
        expect_val(1, 0, 16'h0, "r10_after_clear");
        expect_val(1, 1, 16'h0, "r11_after_clear");
        expect_val(1, 2, 16'h0, "r12_after_clear");

        // 6: reset mid-sweep restarts a full sweep; r20 is past the interrupted pointer
        step();
        set_wr(0, 1'b1, 20, 16'h2020);
        step();
        set_wr(0, 1'b0, 0, 16'h0);
        clear = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            clear = 1'b0;
            expect_val(0, 0, 16'h0, "ready_mid_sweep");
        end
        reset = 1'b0;
        expect_val(0, 0, 16'h0, "ready_reset_mid");
        step();
        expect_val(0, 0, 16'h0, "ready_reset_held");
        step();
        reset = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) step();
            expect_val(0, 0, (k < 32) ? 16'h0 : 16'h1, "ready_resweep");
            expect_val(2, 0, (k < 24) ? 16'h0 : 16'h1, "ready48_resweep");
        end
        wait_ready(40, "wait_ready_resweep");
        step();
        set_rd(0, 20);
        expect_val(1, 0, 16'h0, "r20_after_resweep");

        // 48-entry file: address 50 is dropped and reads 0, address 47 works
        set_wr48(0, 1'b1, 50, 16'h7777);
        set_wr48(1, 1'b1, 47, 16'h4747);
        set_rd48(0, 50);
        expect_val(3, 0, 16'h0, "oor_same_cycle");
        step();
        set_wr48(0, 1'b0, 0, 16'h0);
        set_wr48(1, 1'b0, 0, 16'h0);
        set_rd48(1, 47);
        expect_val(3, 0, 16'h0, "oor_rd50");
        expect_val(3, 1, 16'h4747, "rd47");

        step();
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
